// File: rtl/psum_wb_pkg.sv
// Shared definitions for the SFU write-back path: FSM encoding, SRAM strobe
// levels and the default lane geometry common to the SFU and write-back.
package psum_wb_pkg;

  localparam int PsumBw = 16;
  localparam int Col    = 8;

  localparam logic SramOn  = 1'b0;
  localparam logic SramOff = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/psum_wb_fifo.sv
// Synchronous FIFO between the SFU handshake and the SRAM writer; read data
// is registered on pop and holds its value otherwise.
module psum_wb_fifo #(
  parameter int Width = 128,
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wrPtr_q, rdPtr_q;
  logic [AddrW:0]   cnt_q;
  logic [Width-1:0] dout_q;
  logic             doPush, doPop;

  // Depth is a power of two, so the counter MSB alone marks a full FIFO.
  assign full_o  = cnt_q[AddrW];
  assign empty_o = (cnt_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign dout_o  = dout_q;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        dout_q  <= mem_q[rdPtr_q];
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/psum_wb_ctrl.sv
// Write-back controller: buffers SFU output vectors and streams them into the
// output SRAM at consecutive addresses from a programmed base.
module psum_wb_ctrl
  import psum_wb_pkg::*;
#(
  parameter int psum_bw    = PsumBw,
  parameter int col        = Col,
  parameter int fifo_depth = 8,
  parameter int addr_bw    = 11,
  parameter int cnt_bw     = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [addr_bw-1:0]     base_addr_i,
  input  logic [cnt_bw-1:0]      num_vec_i,
  input  logic                   valid_i,
  input  logic [col*psum_bw-1:0] psum_in,
  output logic                   ready_o,
  output logic                   sram_cen_o,
  output logic                   sram_wen_o,
  output logic [addr_bw-1:0]     sram_addr_o,
  output logic [col*psum_bw-1:0] sram_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o
);

  wb_state_e          state_q, state_d;
  logic [addr_bw-1:0] base_q, addr_q;
  logic [cnt_bw-1:0]  numVec_q, inCnt_q, outCnt_q;
  logic               overflow_q, cen_q;
  logic               fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic               startAcc, inRun, moreIn, ovfSet;

  assign startAcc = (state_q == IDLE) && start_i;
  assign inRun    = (state_q == RUN);
  assign moreIn   = (inCnt_q < numVec_q);
  assign ready_o  = inRun && !fifoFull && moreIn;
  assign fifoPush = valid_i && ready_o;
  assign fifoPop  = inRun && !fifoEmpty;
  assign ovfSet   = valid_i && inRun && fifoFull && moreIn;

  psum_wb_fifo #(
    .Width (col*psum_bw),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .din_i   (psum_in),
    .dout_o  (sram_data_o),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Leaving RUN waits for the cycle after the final strobe so done_o trails it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (num_vec_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (outCnt_q == numVec_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      numVec_q   <= '0;
      inCnt_q    <= '0;
      outCnt_q   <= '0;
      overflow_q <= 1'b0;
      cen_q      <= SramOff;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (startAcc) begin
        base_q     <= base_addr_i;
        numVec_q   <= num_vec_i;
        inCnt_q    <= '0;
        outCnt_q   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (fifoPush) begin
          inCnt_q <= inCnt_q + 1'b1;
        end
        if (fifoPop) begin
          outCnt_q <= outCnt_q + 1'b1;
        end
        if (ovfSet) begin
          overflow_q <= 1'b1;
        end
      end
      cen_q <= fifoPop ? SramOn : SramOff;
      if (fifoPop) begin
        addr_q <= base_q + addr_bw'(outCnt_q);
      end
    end
  end

  assign sram_cen_o  = cen_q;
  assign sram_wen_o  = cen_q;
  assign sram_addr_o = addr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_psum_wb_ctrl.sv
// Directed self-checking bench for psum_wb_ctrl with hand-computed vectors.
module tb_psum_wb_ctrl;
  import psum_wb_pkg::*;

  localparam int DW = Col*PsumBw;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [10:0]   base_addr_i;
  logic [10:0]   num_vec_i;
  logic          valid_i;
  logic [DW-1:0] psum_in;
  logic          ready_o, sram_cen_o, sram_wen_o, busy_o, done_o, overflow_o;
  logic [10:0]   sram_addr_o;
  logic [DW-1:0] sram_data_o;

  int checks = 0;
  int errors = 0;
  int strobeCnt = 0;
  int doneCnt = 0;
  int snap;
  int snapDone;

  psum_wb_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .num_vec_i   (num_vec_i),
    .valid_i     (valid_i),
    .psum_in     (psum_in),
    .ready_o     (ready_o),
    .sram_cen_o  (sram_cen_o),
    .sram_wen_o  (sram_wen_o),
    .sram_addr_o (sram_addr_o),
    .sram_data_o (sram_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  // Count write strobes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sram_cen_o === 1'b0 && sram_wen_o === 1'b0) strobeCnt++;
    if (done_o === 1'b1) doneCnt++;
  end

  function automatic logic [DW-1:0] mkVec(input logic [15:0] b);
    logic [DW-1:0] v;
    v = '0;
    for (int j = 0; j < Col; j++) v[j*PsumBw +: PsumBw] = b + 16'(j);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d);
    valid_i = v;
    psum_in = d;
  endtask

  task automatic startTile(input logic [10:0] b, input logic [10:0] n);
    start_i = 1'b1;
    base_addr_i = b;
    num_vec_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic checkStrobe(input string tag, input logic [10:0] a, input logic [DW-1:0] d);
    checkOutput({tag, "_cen"}, DW'(sram_cen_o), DW'(1'b0));
    checkOutput({tag, "_wen"}, DW'(sram_wen_o), DW'(1'b0));
    checkOutput({tag, "_addr"}, DW'(sram_addr_o), DW'(a));
    checkOutput({tag, "_data"}, sram_data_o, d);
  endtask

  task automatic checkResetOuts(input string tag);
    checkOutput({tag, "_cen"}, DW'(sram_cen_o), DW'(1'b1));
    checkOutput({tag, "_wen"}, DW'(sram_wen_o), DW'(1'b1));
    checkOutput({tag, "_addr"}, DW'(sram_addr_o), '0);
    checkOutput({tag, "_data"}, sram_data_o, '0);
    checkOutput({tag, "_ready"}, DW'(ready_o), '0);
    checkOutput({tag, "_busy"}, DW'(busy_o), '0);
    checkOutput({tag, "_done"}, DW'(done_o), '0);
    checkOutput({tag, "_ovf"}, DW'(overflow_o), '0);
  endtask

  task automatic waitDone(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (done_o === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, DW'(seen), DW'(1'b1));
    tick();
    checkOutput({tag, "_idle"}, DW'(busy_o), '0);
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    num_vec_i = '0;
    applyStimulus(1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    checkResetOuts("reset");

    // Basic tile: base 0x010, four back-to-back vectors.
    startTile(11'h010, 11'd4);
    checkOutput("basic_ready", DW'(ready_o), DW'(1'b1));
    checkOutput("basic_busy", DW'(busy_o), DW'(1'b1));
    applyStimulus(1'b1, mkVec(16'd1));
    tick();
    checkOutput("basic_no_fallthru", DW'(sram_cen_o), DW'(1'b1));
    applyStimulus(1'b1, mkVec(16'd17));
    tick();
    checkStrobe("basic_w0", 11'h010, mkVec(16'd1));
    applyStimulus(1'b1, mkVec(16'd33));
    tick();
    checkStrobe("basic_w1", 11'h011, mkVec(16'd17));
    applyStimulus(1'b1, mkVec(16'd49));
    tick();
    checkStrobe("basic_w2", 11'h012, mkVec(16'd33));
    checkOutput("basic_ready_after_last", DW'(ready_o), '0);
    applyStimulus(1'b0, '0);
    tick();
    checkStrobe("basic_w3", 11'h013, mkVec(16'd49));
    checkOutput("basic_done_early", DW'(done_o), '0);
    tick();
    checkOutput("basic_done", DW'(done_o), DW'(1'b1));
    checkOutput("basic_done_nostrobe", DW'(sram_cen_o), DW'(1'b1));
    checkOutput("basic_done_busy", DW'(busy_o), DW'(1'b1));
    tick();
    checkOutput("basic_done_drop", DW'(done_o), '0);
    checkOutput("basic_busy_drop", DW'(busy_o), '0);

    // Address wrap past 0x7FF.
    startTile(11'h7FE, 11'd4);
    applyStimulus(1'b1, mkVec(16'h0A00));
    tick();
    applyStimulus(1'b1, mkVec(16'h0B00));
    tick();
    checkStrobe("wrap_w0", 11'h7FE, mkVec(16'h0A00));
    applyStimulus(1'b1, mkVec(16'h0C00));
    tick();
    checkStrobe("wrap_w1", 11'h7FF, mkVec(16'h0B00));
    applyStimulus(1'b1, mkVec(16'h0D00));
    tick();
    checkStrobe("wrap_w2", 11'h000, mkVec(16'h0C00));
    applyStimulus(1'b0, '0);
    tick();
    checkStrobe("wrap_w3", 11'h001, mkVec(16'h0D00));
    waitDone("wrap");

    // Back-pressure: hold the reader off so the FIFO fills, then overflow.
    startTile(11'h100, 11'd9);
    force dut.fifoPop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, mkVec(16'h1000 + 16'(k*16)));
      tick();
    end
    checkOutput("bp_full_ready", DW'(ready_o), '0);
    checkOutput("bp_ovf_before", DW'(overflow_o), '0);
    applyStimulus(1'b1, mkVec(16'h2000));
    tick();
    checkOutput("bp_ovf_set", DW'(overflow_o), DW'(1'b1));
    checkOutput("bp_ready_held", DW'(ready_o), '0);
    tick();
    applyStimulus(1'b0, '0);
    snap = strobeCnt;
    release dut.fifoPop;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkStrobe($sformatf("bp_w%0d", k), 11'h100 + 11'(k), mkVec(16'h1000 + 16'(k*16)));
    end
    tick();
    checkOutput("bp_write_count", DW'(strobeCnt - snap), DW'(8));
    checkOutput("bp_ovf_sticky", DW'(overflow_o), DW'(1'b1));
    applyStimulus(1'b1, mkVec(16'h3000));
    tick();
    applyStimulus(1'b0, '0);
    tick();
    checkStrobe("bp_w8", 11'h108, mkVec(16'h3000));
    waitDone("bp");
    checkOutput("bp_ovf_idle", DW'(overflow_o), DW'(1'b1));

    // Stray valid in IDLE, then a two-vector tile with three offered.
    snap = strobeCnt;
    applyStimulus(1'b1, mkVec(16'h4000));
    tick();
    checkOutput("idle_ready", DW'(ready_o), '0);
    tick();
    applyStimulus(1'b0, '0);
    checkOutput("idle_no_write", DW'(strobeCnt - snap), '0);
    startTile(11'h020, 11'd2);
    checkOutput("extra_ovf_cleared", DW'(overflow_o), '0);
    applyStimulus(1'b1, mkVec(16'h5000));
    tick();
    applyStimulus(1'b1, mkVec(16'h5100));
    tick();
    checkOutput("extra_ready_after2", DW'(ready_o), '0);
    checkStrobe("extra_w0", 11'h020, mkVec(16'h5000));
    applyStimulus(1'b1, mkVec(16'h5200));
    tick();
    checkStrobe("extra_w1", 11'h021, mkVec(16'h5100));
    checkOutput("extra_ovf", DW'(overflow_o), '0);
    applyStimulus(1'b0, '0);
    waitDone("extra");
    checkOutput("extra_write_count", DW'(strobeCnt - snap), DW'(2));

    // Zero-count tile goes straight to DONE with no strobe.
    snap = strobeCnt;
    startTile(11'h050, 11'd0);
    checkOutput("zero_done", DW'(done_o), DW'(1'b1));
    checkOutput("zero_busy", DW'(busy_o), DW'(1'b1));
    tick();
    checkOutput("zero_done_drop", DW'(done_o), '0);
    checkOutput("zero_no_write", DW'(strobeCnt - snap), '0);

    // Stray start during RUN must not move the base.
    startTile(11'h200, 11'd2);
    startTile(11'h300, 11'd5);
    applyStimulus(1'b1, mkVec(16'h6000));
    tick();
    applyStimulus(1'b1, mkVec(16'h6100));
    tick();
    checkStrobe("stray_w0", 11'h200, mkVec(16'h6000));
    applyStimulus(1'b0, '0);
    tick();
    checkStrobe("stray_w1", 11'h201, mkVec(16'h6100));
    waitDone("stray");

    // Reset mid-tile after two of six vectors.
    startTile(11'h040, 11'd6);
    applyStimulus(1'b1, mkVec(16'h7000));
    tick();
    applyStimulus(1'b1, mkVec(16'h7100));
    tick();
    applyStimulus(1'b0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetOuts("midrst");
    snap = strobeCnt;
    snapDone = doneCnt;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("midrst_no_write", DW'(strobeCnt - snap), '0);
    checkOutput("midrst_no_done", DW'(doneCnt - snapDone), '0);
    checkOutput("midrst_idle", DW'(busy_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
